// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH cycles,
// with a single carry/borrow flop chaining the bits from LSB to MSB.
module serial_add_sub #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sha_q, shb_q, res_q, res_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               c_q, c_d, ovf_q, sum_bit, last_bit;

    assign sum_bit  = sha_q[0] ^ shb_q[0] ^ c_q;
    assign c_d      = (sha_q[0] & shb_q[0]) | (sha_q[0] & c_q) | (shb_q[0] & c_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at the LSB.
    assign res_d    = (res_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Subtract is a + ~b + ~cin, so the carry flop holds NOT borrow throughout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sha_q <= '0;
            shb_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
            c_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    sha_q <= a;
                    shb_q <= mode ? ~b : b;
                    c_q   <= mode ? ~cin : cin;
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                end
                RUN: begin
                    sha_q <= sha_q >> 1;
                    shb_q <= shb_q >> 1;
                    c_q   <= c_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_bit) ovf_q <= c_q ^ c_d;
                end
                default: ;
            endcase
        end
    end

    assign result   = res_q;
    assign cout     = c_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub at WIDTH=8 and WIDTH=1.
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, mode8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] res8;
    logic       start1 = 1'b0, mode1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] res1;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .result(res8), .cout(cout8),
        .overflow(ovf8)
    );

    serial_add_sub #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .a(a1), .b(b1),
        .cin(cin1), .busy(busy1), .done(done1), .result(res1), .cout(cout1),
        .overflow(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts one WIDTH=8 operation and checks latency, results and hold-after-done.
    task automatic run8(input logic m, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic, input logic [7:0] er, input logic ec,
                        input logic eo, input string tag);
        int early = 0;
        mode8 = m; a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; mode8 = ~m; a8 = ~ia; b8 = ~ib; cin8 = ~ic;
        chk({tag, " busy_after_start"}, 32'(busy8), 32'd1);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            if (done8) early++;
        end
        @(posedge clk); #1;
        chk({tag, " done"}, 32'(done8), 32'd1);
        chk({tag, " early_done"}, 32'(early), 32'd0);
        chk({tag, " result"}, 32'(res8), 32'(er));
        chk({tag, " cout"}, 32'(cout8), 32'(ec));
        chk({tag, " overflow"}, 32'(ovf8), 32'(eo));
        @(posedge clk); #1;
        chk({tag, " busy_after_done"}, 32'(busy8), 32'd0);
        chk({tag, " done_cleared"}, 32'(done8), 32'd0);
        chk({tag, " result_hold"}, 32'(res8), 32'(er));
    endtask

    logic [7:0] add_s  = 8'h96;  // a^b^c indexed by {a,b,cin}
    logic [7:0] add_c  = 8'hE8;  // majority
    logic [7:0] sub_nb = 8'h71;  // NOT borrow of a-b-cin

    initial begin
        int ndone;
        // Reset state
        #3;
        chk("rst busy8", 32'(busy8), 32'd0);
        chk("rst done8", 32'(done8), 32'd0);
        chk("rst result8", 32'(res8), 32'd0);
        chk("rst cout8", 32'(cout8), 32'd0);
        chk("rst ovf8", 32'(ovf8), 32'd0);
        chk("rst busy1", 32'(busy1), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        run8(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add_5a_3c");
        run8(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        run8(1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, "add_7f_cin");
        run8(1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0, "sub_10_20");
        run8(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, "sub_80_01");
        run8(1'b1, 8'h50, 8'h20, 1'b1, 8'h2F, 1'b1, 1'b0, "sub_50_20_b");

        // start pulsed at RUN cycles 3 and 8 must not disturb the operation
        mode8 = 1'b0; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3 || k == 8) begin
                mode8 = 1'b1; a8 = 8'hFF; b8 = 8'hAA; cin8 = 1'b1; start8 = 1'b1;
            end
            @(posedge clk); #1;
            start8 = 1'b0;
            if (done8) begin
                ndone++;
                chk("busy_start result", 32'(res8), 32'h46);
                chk("busy_start cout", 32'(cout8), 32'd0);
            end
        end
        chk("busy_start done_count", 32'(ndone), 32'd1);
        chk("busy_start hold", 32'(res8), 32'h46);

        // Reset asserted mid-RUN discards the operation
        mode8 = 1'b0; a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        for (int k = 0; k < 4; k++) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy8), 32'd0);
        chk("midrst done", 32'(done8), 32'd0);
        chk("midrst result", 32'(res8), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        chk("midrst no_done", 32'(ndone), 32'd0);
        run8(1'b0, 8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0, "after_rst");

        // WIDTH=1 exhaustive truth table
        for (int v = 0; v < 16; v++) begin
            logic [3:0] vv;
            logic [2:0] ix;
            vv = 4'(v);
            ix = vv[2:0];
            mode1 = vv[3]; a1 = vv[2]; b1 = vv[1]; cin1 = vv[0]; start1 = 1'b1;
            @(posedge clk); #1 start1 = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("w1 done m%0d_%0d", vv[3], ix), 32'(done1), 32'd1);
            chk($sformatf("w1 result m%0d_%0d", vv[3], ix), 32'(res1), 32'(add_s[ix]));
            chk($sformatf("w1 cout m%0d_%0d", vv[3], ix), 32'(cout1),
                32'(vv[3] ? sub_nb[ix] : add_c[ix]));
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
